jtag_host: RTL

Host-side JTAG scan engine that drives a target TAP (TCK/TMS/TDI) and captures TDO. The core issues one IR or DR scan per request; the engine walks the target TAP state machine from Run-Test/Idle through the shift states and back. It is the initiator counterpart of the on-chip debug access port and is used to exercise that port in loopback and from an on-chip debug master.

---
 rtl/jtag_host.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_host.sv
// -----------------------------------------------------------------------------
// jtag_host
// Host-side JTAG scan engine. Walks a target TAP from Run-Test/Idle through
// one IR or DR scan per request and back, generating TCK from clk.
//
// Optional feature macro: JTAG_HOST_TLR_CMD_EN
//   defined   : 'tlr' in IDLE runs the 6-bit Test-Logic-Reset sequence and
//               pulses 'done' at its end.
//   undefined : 'tlr' is ignored; TLR only runs after reset release.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   start, ir_sel, len,  scan request (IR/DR select, bit count 1..32, TDI
//   data_in              payload shifted LSB first)
//   tlr                 Test-Logic-Reset request (see macro above)
//   busy, done          sequence in progress / one-cycle completion pulse
//   data_out            captured TDO, bit i = i-th captured bit
//   TCK, TMS, TDI, TDO  JTAG pins
//   o_dbg_state         current FSM state (state_t encoding)
//
// Handshake: 'start' (and 'tlr') are single-cycle requests sampled on the
// clk edge; a request is taken only in a cycle where busy=0, otherwise it is
// dropped. busy rises the cycle after acceptance; done pulses for one cycle
// in the same cycle busy falls, and a new request may be accepted then.
// -----------------------------------------------------------------------------
module jtag_host #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ir_sel,
  input  logic [5:0]  len,
  input  logic [31:0] data_in,
  input  logic        tlr,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TLR   = 3'd1,
    S_HDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_TAIL  = 3'd4
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_div;
  logic        r_tck, r_tms, r_tdi, r_done;
  logic [31:0] r_data_out, r_data;
  logic        r_ir, r_tlr_cmd;
  logic [4:0]  r_last;
  logic        w_tms_nxt, w_tdi_nxt, w_done_nxt;
  logic        w_accept, w_tlr_go, w_tlr_req;
  logic        w_div_wrap, w_tck_rise, w_bit_end;
  logic [4:0]  w_hdr_last, w_last_in;

`ifdef JTAG_HOST_TLR_CMD_EN
  assign w_tlr_req = tlr;
`else
  // Port kept for a uniform interface; the request is masked off.
  assign w_tlr_req = tlr & 1'b0;
`endif

  // Index of the last shift bit; len above 32 clamps to 32 (len=32 wraps
  // its low five bits to 0, so 0-1 gives 31 as well).
  assign w_last_in  = (len > 6'd32) ? 5'd31 : (len[4:0] - 5'd1);
  assign w_hdr_last = r_ir ? 5'd3 : 5'd2;

  // A bit is a low half then a high half; the wrap out of the low half is
  // the TCK rising edge (TDO sample), the wrap out of the high half ends it.
  assign w_div_wrap = (r_state != S_IDLE) && (r_div == DIV_MAX);
  assign w_tck_rise = w_div_wrap && !r_tck;
  assign w_bit_end  = w_div_wrap && r_tck;

  // Next-state / next-pin logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_tlr_go    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tlr_req) begin
          w_state_nxt = S_TLR;
          w_cnt_nxt   = 5'd0;
          w_tlr_go    = 1'b1;
        end else if (start && (len != 6'd0)) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 5'd0;
          w_accept    = 1'b1;
        end
      end
      S_TLR: if (w_bit_end) begin
        if (r_cnt == 5'd5) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = r_tlr_cmd;  // silent after the power-on sequence
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_HDR: if (w_bit_end) begin
        if (r_cnt == w_hdr_last) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_SHIFT: if (w_bit_end) begin
        if (r_cnt == r_last) begin
          w_state_nxt = S_TAIL;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_TAIL: if (w_bit_end) begin
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Pins are registered from the next state so they change exactly at the
    // falling edge / first cycle of a sequence. r_ir and r_data may still be
    // stale on the accept edge, which is harmless: header bit 0 is TMS=1 for
    // both scan types and TDI is 0 outside SHIFT.
    w_tms_nxt = 1'b0;
    w_tdi_nxt = 1'b0;
    case (w_state_nxt)
      S_TLR:   w_tms_nxt = (w_cnt_nxt < 5'd5);
      S_HDR:   w_tms_nxt = (w_cnt_nxt == 5'd0) || (r_ir && (w_cnt_nxt == 5'd1));
      S_SHIFT: begin
        w_tms_nxt = (w_cnt_nxt == r_last);
        w_tdi_nxt = r_data[w_cnt_nxt];
      end
      S_TAIL:  w_tms_nxt = (w_cnt_nxt == 5'd0);
      default: w_tms_nxt = 1'b0;
    endcase
  end

  // State register; reset lands in the TLR sequence so it replays on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_TLR;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // TCK divider, pins and capture datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_tck      <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
      r_data     <= '0;
      r_ir       <= 1'b0;
      r_last     <= 5'd0;
      r_tlr_cmd  <= 1'b0;
    end else begin
      r_tms  <= w_tms_nxt;
      r_tdi  <= w_tdi_nxt;
      r_done <= w_done_nxt;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_tck <= 1'b0;
      end else if (w_div_wrap) begin
        r_div <= '0;
        r_tck <= ~r_tck;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_accept) begin
        r_data     <= data_in;
        r_ir       <= ir_sel;
        r_last     <= w_last_in;
        r_data_out <= '0;
      end else if ((r_state == S_SHIFT) && w_tck_rise) begin
        r_data_out[r_cnt] <= TDO;
      end
      if (w_tlr_go) begin
        r_tlr_cmd <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_tlr_cmd <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign data_out    = r_data_out;
  assign TCK         = r_tck;
  assign TMS         = r_tms;
  assign TDI         = r_tdi;
  assign o_dbg_state = r_state;

endmodule
